// File: rtl/key_panel.sv
// rtl/key_panel.sv - debounced push-button panel with press/release pulses, hold flag and auto-repeat.
// One sample-tick divider is shared by all channels; every channel's state is otherwise private.
module key_panel #(
    parameter int N_KEYS       = 5,
    parameter int SAMPLE_DIV   = 100000,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_i,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_hold,
    output logic              any_press
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int STB_W = $clog2(STABLE_CNT + 1);
    localparam int HLD_W = $clog2(REPEAT_DELAY + 1);
    localparam int REP_W = (REPEAT_RATE > 0) ? $clog2(REPEAT_RATE + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [STB_W-1:0] STB_TOP  = STB_W'(STABLE_CNT);
    localparam logic [HLD_W-1:0] HLD_TOP  = HLD_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_TOP  = REP_W'(REPEAT_RATE);

    logic [DIV_W-1:0]              div_q, div_d;
    logic [N_KEYS-1:0]             sync1_q, sync1_d;
    logic [N_KEYS-1:0]             sync2_q, sync2_d;
    logic [N_KEYS-1:0]             level_q, level_d;
    logic [N_KEYS-1:0]             level_dly_q, level_dly_d;
    logic [N_KEYS-1:0][STB_W-1:0]  stb_q, stb_d;
    logic [N_KEYS-1:0][HLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N_KEYS-1:0][REP_W-1:0]  rep_q, rep_d;
    logic [N_KEYS-1:0]             rep_evt_q, rep_evt_d;
    logic [N_KEYS-1:0]             press_q, press_d;
    logic [N_KEYS-1:0]             release_q, release_d;
    logic [N_KEYS-1:0]             hold_q, hold_d;
    logic                          tick;

    always_comb begin
        tick        = (div_q == DIV_LAST);
        div_d       = tick ? '0 : div_q + 1'b1;
        sync1_d     = keys_i;
        sync2_d     = sync1_q;
        level_dly_d = level_q;
        press_d     = (level_q & ~level_dly_q) | rep_evt_q;
        release_d   = ~level_q & level_dly_q;
        level_d     = level_q;
        stb_d       = stb_q;
        hold_cnt_d  = hold_cnt_q;
        rep_d       = rep_q;
        rep_evt_d   = '0;
        hold_d      = '0;

        for (int i = 0; i < N_KEYS; i++) begin
            hold_d[i] = level_q[i] && (hold_cnt_q[i] == HLD_TOP);

            if (tick) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (stb_q[i] == STB_TOP - 1'b1) begin
                        level_d[i] = ~level_q[i];
                        stb_d[i]   = '0;
                    end else begin
                        stb_d[i] = stb_q[i] + 1'b1;
                    end
                end else begin
                    stb_d[i] = '0;
                end
            end

            // Hold counter saturates at REPEAT_DELAY; the repeat sub-counter only runs once it has.
            if (!level_q[i]) begin
                hold_cnt_d[i] = '0;
                rep_d[i]      = '0;
            end else if (tick) begin
                if (hold_cnt_q[i] != HLD_TOP) begin
                    hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                    rep_evt_d[i]  = (REPEAT_RATE > 0) && (hold_cnt_q[i] == HLD_TOP - 1'b1)
                                    && level_d[i];
                end else if (REPEAT_RATE > 0) begin
                    if (rep_q[i] == REP_TOP - 1'b1) begin
                        rep_d[i]     = '0;
                        rep_evt_d[i] = level_d[i];
                    end else begin
                        rep_d[i] = rep_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            stb_q       <= '0;
            hold_cnt_q  <= '0;
            rep_q       <= '0;
            rep_evt_q   <= '0;
            press_q     <= '0;
            release_q   <= '0;
            hold_q      <= '0;
        end else begin
            div_q       <= div_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            stb_q       <= stb_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_q       <= rep_d;
            rep_evt_q   <= rep_evt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            hold_q      <= hold_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_hold    = hold_q;
    assign any_press   = |press_q;

endmodule

// File: tb/tb_key_panel.sv
// tb/tb_key_panel.sv - directed bench for key_panel with a press/release event scoreboard.
module tb_key_panel;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] keys_i, keys2;
    logic [2:0] key_level, key_press, key_release, key_hold;
    logic       any_press;
    logic [2:0] level_z, press_z, release_z, hold_z;
    logic       any_z;

    always #5 clk = ~clk;

    key_panel #(.N_KEYS(3), .SAMPLE_DIV(4), .STABLE_CNT(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)) dut (
        .clk(clk), .rst(rst), .keys_i(keys_i), .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_hold(key_hold), .any_press(any_press));

    key_panel #(.N_KEYS(3), .SAMPLE_DIV(4), .STABLE_CNT(3), .REPEAT_DELAY(5), .REPEAT_RATE(0)) dut_z (
        .clk(clk), .rst(rst), .keys_i(keys2), .key_level(level_z), .key_press(press_z),
        .key_release(release_z), .key_hold(hold_z), .any_press(any_z));

    typedef struct {
        int         edge_no;
        logic [2:0] press;
        logic [2:0] rel;
    } evt_t;

    evt_t sb[$];
    int   edge_cnt;
    int   checks = 0;
    int   errors = 0;
    int   z_press_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_tick(input int k0);
        int t = k0 + 3;
        while (t % 4 != 0) t++;
        return t;
    endfunction

    task automatic at_edge(input int k);
        while (edge_cnt < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int e, input logic [2:0] p, input logic [2:0] r);
        evt_t ev;
        ev.edge_no = e;
        ev.press   = p;
        ev.rel     = r;
        sb.push_back(ev);
    endtask

    initial begin
        evt_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (press_z[0]) z_press_cnt++;
                if ((key_press | key_release) != 3'b000) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_evt", {26'd0, key_press, key_release}, 32'd0);
                    end else begin
                        ev = sb.pop_front();
                        chk("evt_edge", edge_cnt, ev.edge_no);
                        chk("evt_press", key_press, ev.press);
                        chk("evt_release", key_release, ev.rel);
                        chk("evt_any_press", any_press, (ev.press != 3'b000));
                    end
                end
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int e, l, r0, f;
        rst    = 1'b1;
        keys_i = '0;
        keys2  = '0;
        repeat (3) @(negedge clk);
        chk("rst_level", key_level, 3'b000);
        chk("rst_pulses", {key_press, key_release, any_press}, 7'd0);
        chk("rst_hold", key_hold, 3'b000);
        rst = 1'b0;

        // Long hold on key 0: press, repeats every 2 ticks after 5, single release.
        at_edge(2);
        e = edge_cnt;
        keys_i = 3'b001;
        keys2  = 3'b001;
        l  = first_tick(e) + 8;
        r0 = l + 74;
        f  = first_tick(r0) + 8;
        push(l + 1, 3'b001, 3'b000);
        for (int n = 5; l + 4 * n < f; n += 2) push(l + 4 * n + 1, 3'b001, 3'b000);
        push(f + 1, 3'b000, 3'b001);
        at_edge(l - 1);
        chk("lvl0_before", key_level, 3'b000);
        at_edge(l);
        chk("lvl0_rise", key_level, 3'b001);
        chk("press_not_yet", key_press, 3'b000);
        at_edge(l + 20);
        chk("hold_early", key_hold, 3'b000);
        chk("hold_z_early", hold_z, 3'b000);
        at_edge(l + 21);
        chk("hold_on", key_hold, 3'b001);
        chk("hold_z_on", hold_z, 3'b001);
        at_edge(r0);
        keys_i = '0;
        keys2  = '0;
        at_edge(f);
        chk("hold_before_rel", key_hold, 3'b001);
        at_edge(f + 1);
        chk("hold_off_at_rel", key_hold, 3'b000);
        chk("hold_z_off", hold_z, 3'b000);
        chk("release_z", release_z, 3'b001);
        chk("z_single_press", z_press_cnt, 1);
        at_edge(f + 4);
        chk("sb_empty_a", sb.size(), 0);

        // Two-tick glitch on key 1 must not reach the debounced level.
        e = (edge_cnt / 4 + 1) * 4;
        at_edge(e);
        keys_i = 3'b010;
        at_edge(e + 8);
        keys_i = 3'b000;
        at_edge(e + 24);
        chk("glitch_level", key_level, 3'b000);

        // Keys 0 and 2 together.
        at_edge(edge_cnt + 1);
        e = edge_cnt;
        keys_i = 3'b101;
        l = first_tick(e) + 8;
        f = first_tick(l) + 8;
        push(l + 1, 3'b101, 3'b000);
        push(f + 1, 3'b000, 3'b101);
        at_edge(l);
        keys_i = 3'b000;
        at_edge(l + 1);
        chk("any_press_hi", any_press, 1'b1);
        at_edge(l + 2);
        chk("any_press_lo", any_press, 1'b0);
        at_edge(f + 4);
        chk("sb_empty_b", sb.size(), 0);

        // Reset while key 1 is in hold, key kept pressed through reset.
        at_edge(edge_cnt + 1);
        e = edge_cnt;
        keys_i = 3'b010;
        l = first_tick(e) + 8;
        push(l + 1, 3'b010, 3'b000);
        push(l + 21, 3'b010, 3'b000);
        at_edge(l + 21);
        chk("hold1_on", key_hold, 3'b010);
        at_edge(l + 22);
        chk("sb_empty_c", sb.size(), 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_level", key_level, 3'b000);
        chk("mid_rst_hold", key_hold, 3'b000);
        chk("mid_rst_pulses", {key_press, key_release, any_press}, 7'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(13, 3'b010, 3'b000);
        at_edge(11);
        chk("relevel_before", key_level, 3'b000);
        at_edge(12);
        chk("relevel", key_level, 3'b010);
        at_edge(16);
        keys_i = 3'b000;
        push(29, 3'b000, 3'b010);
        at_edge(36);
        chk("final_level", key_level, 3'b000);
        chk("sb_empty_d", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
